// File: rtl/alu_arbiter_if.sv
// Requester/response channel bundle between the two ALU requesters and alu_arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of the single MIPS ALU between the EX stage (req0) and the
// aux/debug path (req1); one ALU cycle per operation, result returned over valid/ready.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   alu_arbiter_if.slave     bus,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   input  logic [WIDTH-1:0] alu_out,
   output logic             busy,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic             last_grant;   // 1 = requester 1 won last, so requester 0 is favoured
   logic             winner;
   logic             grant0;
   logic             grant1;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             rsp_taken;

   assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
   assign grant1 = bus.req1_valid && !grant0;

   // Gated by reset_n so ready is low for the whole reset window, not just after the first edge
   assign bus.req0_ready = reset_n && (state == IDLE) && grant0;
   assign bus.req1_ready = reset_n && (state == IDLE) && grant1;

   assign sel_op = grant1 ? bus.req1_op : bus.req0_op;
   assign sel_a  = grant1 ? bus.req1_a  : bus.req0_a;
   assign sel_b  = grant1 ? bus.req1_b  : bus.req0_b;

   assign rsp_taken = winner ? bus.rsp1_ready : bus.rsp0_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         winner         <= 1'b0;
         alu_op         <= '0;
         alu_in1        <= '0;
         alu_in2        <= '0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp_data   <= '0;
         bus.rsp_err    <= 1'b0;
         busy           <= 1'b0;
         op_count       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  winner     <= grant1;
                  last_grant <= grant1;
                  busy       <= 1'b1;
                  if (sel_op <= 3'd5) begin
                     state   <= EXEC;
                     alu_op  <= sel_op;
                     alu_in1 <= sel_a;
                     alu_in2 <= sel_b;
                  end else begin
                     // Illegal op bypasses the ALU entirely
                     state          <= RESP;
                     bus.rsp_data   <= '0;
                     bus.rsp_err    <= 1'b1;
                     bus.rsp0_valid <= !grant1;
                     bus.rsp1_valid <= grant1;
                  end
               end
            end
            EXEC: begin
               state          <= RESP;
               alu_op         <= '0;
               alu_in1        <= '0;
               alu_in2        <= '0;
               bus.rsp_data   <= alu_out;
               bus.rsp_err    <= 1'b0;
               bus.rsp0_valid <= !winner;
               bus.rsp1_valid <= winner;
            end
            RESP: begin
               if (rsp_taken) begin
                  state          <= IDLE;
                  busy           <= 1'b0;
                  bus.rsp0_valid <= 1'b0;
                  bus.rsp1_valid <= 1'b0;
                  if (op_count != 16'hFFFF) begin
                     op_count <= op_count + 16'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model answers alu_op/in1/in2,
// and each scenario task checks handshakes, ALU drive, responses and op_count.
module tb_alu_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [2:0]  alu_op;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_out;
   logic        busy;
   logic [15:0] op_count;

   int vectors = 0;
   int miscompares = 0;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .bus      (bus),
      .alu_op   (alu_op),
      .alu_in1  (alu_in1),
      .alu_in2  (alu_in2),
      .alu_out  (alu_out),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clock = ~clock;

   always_comb begin
      case (alu_op)
         3'd0:    alu_out = alu_in1;
         3'd1:    alu_out = alu_in1 + alu_in2;
         3'd2:    alu_out = alu_in1 - alu_in2;
         3'd3:    alu_out = alu_in1 & alu_in2;
         3'd4:    alu_out = alu_in1 | alu_in2;
         3'd5:    alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
         default: alu_out = 32'd0;
      endcase
   end

   task automatic run_one(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output logic err, output bit ok);
      bit accepted = 1'b0;
      ok = 1'b0;
      data = '0;
      err = 1'b0;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;
      if (id) begin
         bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
      end else begin
         bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
      end
      #1;
      for (int c = 0; c < 10; c++) begin
         if (id ? bus.req1_ready : bus.req0_ready) begin
            accepted = 1'b1;
            break;
         end
         @(negedge clock);
      end
      @(negedge clock);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (accepted) begin
         for (int c = 0; c < 10; c++) begin
            if (id ? bus.rsp1_valid : bus.rsp0_valid) begin
               data = bus.rsp_data;
               err = bus.rsp_err;
               ok = 1'b1;
               break;
            end
            @(negedge clock);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
      bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
      repeat (2) @(negedge clock);
      vectors++;
      if ({busy, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: busy/rv0/rv1/err/rdy0/rdy1=%b, expected 000000",
                  {busy, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.req0_ready, bus.req1_ready});
      end
      vectors++;
      if ({alu_op, alu_in1, alu_in2, bus.rsp_data, op_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: alu_op=%0d in1=%h in2=%h data=%h count=%0d, expected all 0",
                  alu_op, alu_in1, alu_in2, bus.rsp_data, op_count);
      end
      bus.req0_valid = 1'b0;
      #2 reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_add();
      bus.rsp0_ready = 1'b1;
      bus.req0_op = 3'd1; bus.req0_a = 32'd5; bus.req0_b = 32'd7; bus.req0_valid = 1'b1;
      #1;
      vectors++;
      if ({bus.req0_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL add_accept: ready/busy=%b, expected 10", {bus.req0_ready, busy});
      end
      @(negedge clock);
      bus.req0_valid = 1'b0;
      vectors++;
      if ({alu_op, alu_in1, alu_in2} !== {3'd1, 32'd5, 32'd7}) begin
         miscompares++;
         $display("FAIL add_exec: alu_op=%0d in1=%0d in2=%0d, expected 1/5/7", alu_op, alu_in1, alu_in2);
      end
      vectors++;
      if ({busy, bus.rsp0_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL add_exec_state: busy/rv0=%b, expected 10", {busy, bus.rsp0_valid});
      end
      @(negedge clock);
      vectors++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err, bus.rsp_data} !== {3'b100, 32'd12}) begin
         miscompares++;
         $display("FAIL add_resp: rv0/rv1/err=%b data=%0d, expected 100 data=12",
                  {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err}, bus.rsp_data);
      end
      vectors++;
      if ({alu_op, alu_in1, alu_in2} !== '0) begin
         miscompares++;
         $display("FAIL add_alu_idle: alu_op=%0d in1=%0d in2=%0d, expected 0/0/0", alu_op, alu_in1, alu_in2);
      end
      @(negedge clock);
      vectors++;
      if ({bus.rsp0_valid, busy, op_count} !== {2'b00, 16'd1}) begin
         miscompares++;
         $display("FAIL add_done: rv0=%b busy=%b count=%0d, expected 0 0 1", bus.rsp0_valid, busy, op_count);
      end
   endtask

   task automatic test_back_to_back();
      bit exp1;
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      bus.req0_op = 3'd2; bus.req0_a = 32'd10;   bus.req0_b = 32'd3;
      bus.req1_op = 3'd3; bus.req1_a = 32'hF0;   bus.req1_b = 32'h3C;
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp1 = (i % 2) == 1;
         for (int c = 0; c < 8 && !(bus.req0_ready || bus.req1_ready); c++) @(negedge clock);
         vectors++;
         if ({bus.req1_ready, bus.req0_ready} !== (exp1 ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL rr_grant%0d: rdy1/rdy0=%b, expected %b", i,
                     {bus.req1_ready, bus.req0_ready}, exp1 ? 2'b10 : 2'b01);
         end
         @(negedge clock);
         vectors++;
         if ({busy, bus.rsp1_valid, bus.rsp0_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL rr_exec%0d: busy/rv1/rv0=%b, expected 100", i, {busy, bus.rsp1_valid, bus.rsp0_valid});
         end
         @(negedge clock);
         vectors++;
         if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data} !==
             {(exp1 ? 2'b10 : 2'b01), (exp1 ? 32'h30 : 32'd7)}) begin
            miscompares++;
            $display("FAIL rr_resp%0d: rv1/rv0=%b data=%h, expected %b data=%h", i,
                     {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp_data,
                     exp1 ? 2'b10 : 2'b01, exp1 ? 32'h30 : 32'd7);
         end
         @(negedge clock);
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      vectors++;
      if (op_count !== 16'd4) begin
         miscompares++;
         $display("FAIL rr_count: count=%0d, expected 4", op_count);
      end
   endtask

   task automatic test_illegal();
      bus.rsp1_ready = 1'b1;
      bus.req1_op = 3'd6; bus.req1_a = 32'hDEADBEEF; bus.req1_b = 32'd1; bus.req1_valid = 1'b1;
      #1;
      vectors++;
      if ({bus.req1_ready, alu_op} !== {1'b1, 3'd0}) begin
         miscompares++;
         $display("FAIL ill_accept: rdy1=%b alu_op=%0d, expected 1 0", bus.req1_ready, alu_op);
      end
      @(negedge clock);
      bus.req1_valid = 1'b0;
      vectors++;
      if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err, bus.rsp_data} !== {3'b101, 32'd0}) begin
         miscompares++;
         $display("FAIL ill_resp: rv1/rv0/err=%b data=%h, expected 101 data=0",
                  {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err}, bus.rsp_data);
      end
      vectors++;
      if ({alu_op, alu_in1, alu_in2} !== '0) begin
         miscompares++;
         $display("FAIL ill_alu: alu_op=%0d in1=%h in2=%h, expected 0", alu_op, alu_in1, alu_in2);
      end
      @(negedge clock);
      vectors++;
      if ({bus.rsp1_valid, busy, op_count} !== {2'b00, 16'd5}) begin
         miscompares++;
         $display("FAIL ill_done: rv1=%b busy=%b count=%0d, expected 0 0 5", bus.rsp1_valid, busy, op_count);
      end
   endtask

   task automatic test_backpressure();
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
      bus.req0_op = 3'd4; bus.req0_a = 32'hA; bus.req0_b = 32'h5; bus.req0_valid = 1'b1;
      bus.req1_op = 3'd1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_valid = 1'b1;
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL bp_grant: rdy0/rdy1=%b, expected 10", {bus.req0_ready, bus.req1_ready});
      end
      @(negedge clock);
      bus.req0_valid = 1'b0;
      vectors++;
      if ({bus.req1_ready, alu_op, alu_in1, alu_in2} !== {1'b0, 3'd4, 32'hA, 32'h5}) begin
         miscompares++;
         $display("FAIL bp_exec: rdy1=%b alu_op=%0d in1=%h in2=%h, expected 0 4 a 5",
                  bus.req1_ready, alu_op, alu_in1, alu_in2);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         vectors++;
         if ({bus.rsp0_valid, bus.rsp_err, bus.req1_ready, alu_op, bus.rsp_data} !== {3'b100, 3'd0, 32'hF}) begin
            miscompares++;
            $display("FAIL bp_hold%0d: rv0/err/rdy1=%b alu_op=%0d data=%h, expected 100 0 f", k,
                     {bus.rsp0_valid, bus.rsp_err, bus.req1_ready}, alu_op, bus.rsp_data);
         end
      end
      bus.rsp0_ready = 1'b1;
      @(negedge clock);
      vectors++;
      if ({bus.rsp0_valid, bus.req1_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL bp_release: rv0/rdy1=%b, expected 01", {bus.rsp0_valid, bus.req1_ready});
      end
      @(negedge clock);
      bus.req1_valid = 1'b0;
      @(negedge clock);
      vectors++;
      if ({bus.rsp1_valid, bus.rsp_data} !== {1'b1, 32'd3}) begin
         miscompares++;
         $display("FAIL bp_req1_resp: rv1=%b data=%0d, expected 1 3", bus.rsp1_valid, bus.rsp_data);
      end
      @(negedge clock);
      vectors++;
      if (op_count !== 16'd7) begin
         miscompares++;
         $display("FAIL bp_count: count=%0d, expected 7", op_count);
      end
   endtask

   task automatic test_reset_mid();
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      bus.req0_op = 3'd1; bus.req0_a = 32'd2; bus.req0_b = 32'd2; bus.req0_valid = 1'b1;
      #1;
      @(negedge clock);
      bus.req0_valid = 1'b0;
      vectors++;
      if (alu_op !== 3'd1) begin
         miscompares++;
         $display("FAIL rm_exec: alu_op=%0d, expected 1", alu_op);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({alu_op, alu_in1, alu_in2, busy, bus.rsp0_valid, op_count} !== '0) begin
         miscompares++;
         $display("FAIL rm_async: alu_op=%0d in1=%0d busy=%b rv0=%b count=%0d, expected all 0",
                  alu_op, alu_in1, busy, bus.rsp0_valid, op_count);
      end
      #1 reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         vectors++;
         if ({bus.rsp0_valid, busy, op_count} !== '0) begin
            miscompares++;
            $display("FAIL rm_dropped%0d: rv0=%b busy=%b count=%0d, expected 0 0 0",
                     k, bus.rsp0_valid, busy, op_count);
         end
      end
      bus.req0_op = 3'd0; bus.req0_a = 32'h55; bus.req0_b = 32'd0; bus.req0_valid = 1'b1;
      bus.req1_op = 3'd0; bus.req1_a = 32'h66; bus.req1_b = 32'd0; bus.req1_valid = 1'b1;
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL rm_first_grant: rdy0/rdy1=%b, expected 10", {bus.req0_ready, bus.req1_ready});
      end
      @(negedge clock);
      bus.req0_valid = 1'b0;
      @(negedge clock);
      vectors++;
      if ({bus.rsp0_valid, bus.rsp_data} !== {1'b1, 32'h55}) begin
         miscompares++;
         $display("FAIL rm_fwd0: rv0=%b data=%h, expected 1 55", bus.rsp0_valid, bus.rsp_data);
      end
      @(negedge clock);
      @(negedge clock);
      bus.req1_valid = 1'b0;
      @(negedge clock);
      vectors++;
      if ({bus.rsp1_valid, bus.rsp_data} !== {1'b1, 32'h66}) begin
         miscompares++;
         $display("FAIL rm_fwd1: rv1=%b data=%h, expected 1 66", bus.rsp1_valid, bus.rsp_data);
      end
      @(negedge clock);
      vectors++;
      if (op_count !== 16'd2) begin
         miscompares++;
         $display("FAIL rm_count: count=%0d, expected 2", op_count);
      end
   endtask

   task automatic test_saturate();
      logic [31:0] data;
      logic        err;
      bit          ok;
      force dut.op_count = 16'hFFFE;
      #1;
      release dut.op_count;
      #1;
      run_one(1'b0, 3'd1, 32'd100, 32'd23, data, err, ok);
      vectors++;
      if ({ok, err, data, op_count} !== {2'b10, 32'd123, 16'hFFFF}) begin
         miscompares++;
         $display("FAIL sat_first: ok=%b err=%b data=%0d count=%h, expected 1 0 123 ffff", ok, err, data, op_count);
      end
      run_one(1'b1, 3'd5, 32'd3, 32'd9, data, err, ok);
      vectors++;
      if ({ok, err, data, op_count} !== {2'b10, 32'd1, 16'hFFFF}) begin
         miscompares++;
         $display("FAIL sat_hold: ok=%b err=%b data=%0d count=%h, expected 1 0 1 ffff", ok, err, data, op_count);
      end
      run_one(1'b0, 3'd7, 32'd1, 32'd1, data, err, ok);
      vectors++;
      if ({ok, err, data, op_count} !== {2'b11, 32'd0, 16'hFFFF}) begin
         miscompares++;
         $display("FAIL sat_illegal: ok=%b err=%b data=%0d count=%h, expected 1 1 0 ffff", ok, err, data, op_count);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
